// File: rtl/key_schedule_gen.sv
// Round-key schedule sequencer: rotates the PC-1 halves through 16 rounds,
// in encryption or reverse (decryption) order, with a valid/ready key handshake.
module key_schedule_gen (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Decrypt,
    input  logic [55:0] C0_in,
    input  logic [55:0] D0_in,
    input  logic        Key_ready,
    output logic        Key_valid,
    output logic [55:0] Ck,
    output logic [55:0] Dk,
    output logic [3:0]  Round_idx,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic        mode;
    logic        accept;
    logic        last_key;
    logic [3:0]  shift_sel;
    logic        shift_by4;

    // Fixed 2/4-bit circular rotation of one 56-bit half; halves never mix.
    function automatic logic [55:0] rot(input logic [55:0] x, input logic right,
                                        input logic by4);
        logic [55:0] r;
        case ({right, by4})
            2'b00:   r = {x[53:0], x[55:54]};
            2'b01:   r = {x[51:0], x[55:52]};
            2'b10:   r = {x[1:0],  x[55:2]};
            default: r = {x[3:0],  x[55:4]};
        endcase
        return r;
    endfunction

    assign Key_valid = (state == ROUND);
    assign Busy      = (state == ROUND);
    assign Done      = (state == DONE);
    assign accept    = Key_valid & Key_ready;
    assign last_key  = (Round_idx == 4'd15);

    // Encryption walks the shift table forward, decryption walks it backward.
    assign shift_sel = mode ? (4'd15 - Round_idx) : (Round_idx + 4'd1);
    assign shift_by4 = !(shift_sel == 4'd0 || shift_sel == 4'd1 ||
                         shift_sel == 4'd8 || shift_sel == 4'd15);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = ROUND;
            ROUND:   if (accept && last_key) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Ck        <= '0;
            Dk        <= '0;
            Round_idx <= '0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    mode      <= Decrypt;
                    Round_idx <= '0;
                    // Decryption key 0 is the unrotated input; encryption applies s[0]=2.
                    Ck        <= Decrypt ? C0_in : rot(C0_in, 1'b0, 1'b0);
                    Dk        <= Decrypt ? D0_in : rot(D0_in, 1'b0, 1'b0);
                end
                ROUND: if (accept && !last_key) begin
                    Round_idx <= Round_idx + 4'd1;
                    Ck        <= rot(Ck, mode, shift_by4);
                    Dk        <= rot(Dk, mode, shift_by4);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Scoreboard bench for key_schedule_gen: stimulus queues expected keys, a
// negedge monitor checks every accepted key, Done pulses and stall stability.
module tb_key_schedule_gen;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Decrypt = 1'b0;
    logic [55:0] C0_in = '0;
    logic [55:0] D0_in = '0;
    logic        Key_ready = 1'b1;
    logic        Key_valid;
    logic [55:0] Ck, Dk;
    logic [3:0]  Round_idx;
    logic        Busy, Done;

    key_schedule_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Decrypt(Decrypt),
        .C0_in(C0_in), .D0_in(D0_in), .Key_ready(Key_ready),
        .Key_valid(Key_valid), .Ck(Ck), .Dk(Dk), .Round_idx(Round_idx),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic [55:0] ck;
        logic [55:0] dk;
    } key_t;

    localparam logic [55:0] MSB = 56'h80000000000000;

    key_t exp_q[$];
    int   done_pend = 0;
    int   checks = 0;
    int   errors = 0;
    int   s_tab[16] = '{2,2,4,4,4,4,4,4,2,4,4,4,4,4,4,2};

    function automatic logic [55:0] rotl(input logic [55:0] x, input int n);
        logic [111:0] t;
        t = {x, x};
        return t[111-n -: 56];
    endfunction

    // Key i as a single rotation of the latched halves by the cumulative shift.
    function automatic key_t exp_key(input logic [55:0] c0, input logic [55:0] d0,
                                     input logic dec, input int i);
        key_t k;
        int cum = 0;
        if (!dec) for (int j = 0; j <= i; j++) cum += s_tab[j];
        else      for (int j = 16 - i; j <= 15; j++) cum += s_tab[j];
        if (dec) cum = 56 - cum;
        k.idx = i[3:0];
        k.ck  = rotl(c0, cum);
        k.dk  = rotl(d0, cum);
        return k;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue Start at the next edge; returns at edge+1 with key 0 expected on the outputs.
    task automatic start_sched(input logic [55:0] c0, input logic [55:0] d0, input logic dec);
        C0_in = c0; D0_in = d0; Decrypt = dec; Start = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_key(c0, d0, dec, i));
        done_pend++;
        @(posedge Clk); #1;
        Start = 1'b0; C0_in = ~c0; D0_in = ~d0; Decrypt = ~dec;
    endtask

    task automatic wait_idx(input logic [3:0] n);
        int k = 0;
        do begin
            @(posedge Clk); #1; k++;
        end while (!(Key_valid && Round_idx == n) && k < 100);
        if (k >= 100) chk("wait_idx_timeout", {60'd0, Round_idx}, {60'd0, n});
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge.
    logic        held = 1'b0;
    logic [55:0] h_ck, h_dk;
    logic [3:0]  h_idx;
    always @(negedge Clk) begin
        if (!Reset_n) begin
            held = 1'b0;
        end else begin
            if (held && Key_valid) begin
                chk("stall_ck", Ck, h_ck);
                chk("stall_dk", Dk, h_dk);
                chk("stall_idx", Round_idx, h_idx);
            end
            if (Key_valid && Key_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_key actual idx=%0d required none", Round_idx);
                end else begin
                    key_t e;
                    e = exp_q.pop_front();
                    chk("key_idx", Round_idx, e.idx);
                    chk("key_ck", Ck, e.ck);
                    chk("key_dk", Dk, e.dk);
                end
            end
            if (Done) begin
                checks++;
                if (done_pend == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else done_pend--;
            end
            held  = Key_valid && !Key_ready;
            h_ck  = Ck; h_dk = Dk; h_idx = Round_idx;
        end
    end

    initial begin
        #12;
        chk("rst_valid", Key_valid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_idx", Round_idx, 0);
        chk("rst_ck", Ck, 0);
        chk("rst_dk", Dk, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Encryption run
        start_sched(56'h1, MSB, 1'b0);
        chk("enc_latency_valid", Key_valid, 1);
        chk("enc_k0_ck", Ck, 56'h4);
        chk("enc_k0_dk", Dk, 56'h2);
        wait_idx(4'd15);
        chk("enc_k15_ck", Ck, 56'h1);
        chk("enc_k15_dk", Dk, MSB);
        @(posedge Clk); #1;
        chk("enc_done_pulse", Done, 1);
        chk("enc_done_valid", Key_valid, 0);
        chk("enc_done_hold_ck", Ck, 56'h1);
        @(posedge Clk); #1;
        chk("enc_done_one_cycle", Done, 0);

        // Decryption run, with Start asserted during the Done cycle
        start_sched(56'h1, MSB, 1'b1);
        chk("dec_k0_ck", Ck, 56'h1);
        chk("dec_k0_dk", Dk, MSB);
        @(posedge Clk); #1;
        chk("dec_k1_ck", Ck, 56'h40000000000000);
        chk("dec_k1_idx", Round_idx, 1);
        wait_idx(4'd15);
        @(posedge Clk); #1;
        chk("dec_done_pulse", Done, 1);
        Start = 1'b1; C0_in = 56'h123; Decrypt = 1'b0;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("start_on_done_ignored", Key_valid, 0);

        // Stall at index 3
        start_sched(56'h0123456789ABCD, 56'hFEDCBA98765432, 1'b0);
        wait_idx(4'd3);
        Key_ready = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        chk("stall_idx_held", Round_idx, 3);
        Key_ready = 1'b1;
        @(posedge Clk); #1;
        chk("stall_release_idx", Round_idx, 4);
        wait_idx(4'd15);
        repeat (2) @(posedge Clk);
        #1;

        // Start while busy at index 7
        start_sched(56'hA5A5A5A5A5A5A5, 56'h5A5A0000111122, 1'b0);
        wait_idx(4'd7);
        Start = 1'b1; C0_in = 56'hFFFF; D0_in = '0; Decrypt = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("busy_start_idx", Round_idx, 8);
        wait_idx(4'd15);
        repeat (5) @(posedge Clk);
        #1;
        chk("busy_keys_left", exp_q.size(), 0);
        chk("busy_done_left", done_pend, 0);

        // Asynchronous reset at index 9
        start_sched(56'h1, MSB, 1'b0);
        wait_idx(4'd9);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_valid", Key_valid, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_ck", Ck, 0);
        chk("arst_dk", Dk, 0);
        exp_q.delete();
        done_pend = 0;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        start_sched(56'h1, MSB, 1'b0);
        chk("post_rst_k0_ck", Ck, 56'h4);
        chk("post_rst_k0_dk", Dk, 56'h2);
        wait_idx(4'd15);
        repeat (3) @(posedge Clk);
        #1;
        chk("final_keys_left", exp_q.size(), 0);
        chk("final_done_left", done_pend, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_gen.md
KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

Interface
REQ-001 The block SHALL use these ports: Clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 Reset_n, input, 1: asynchronous, active-low reset.
REQ-003 Start, input, 1: request a new 16-round schedule; sampled only in IDLE.
REQ-004 Decrypt, input, 1: mode select; 0 = encryption order K1..K16, 1 = decryption order K16..K1.
REQ-005 C0_in, input, 56: left half produced by the PC-1 stage.
REQ-006 D0_in, input, 56: right half produced by the PC-1 stage.
REQ-007 Key_ready, input, 1: downstream accepts the current round key.
REQ-008 Key_valid, output, 1: Ck/Dk/Round_idx hold a valid round key.
REQ-009 Ck, output, 56: rotated left half for the current round; PC-2 is applied downstream.
REQ-010 Dk, output, 56: rotated right half for the current round.
REQ-011 Round_idx, output, 4: issue index 0..15 of the current key.
REQ-012 Busy, output, 1: high in ROUND state.
REQ-013 Done, output, 1: one-cycle pulse after the 16th key is accepted.

Function
REQ-014 FSM SHALL have three states: IDLE, ROUND and DONE.
- IDLE -> ROUND on Start.
- ROUND -> DONE on acceptance of the key with Round_idx=15.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 On Start in IDLE, the block SHALL latch C0_in, D0_in and Decrypt, and set Round_idx=0.
REQ-016 The first key SHALL be presented with Key_valid=1 in the cycle after Start (latency 1).
REQ-017 Encryption shift table SHALL be s = 2,2,4,4,4,4,4,4,2,4,4,4,4,4,4,2 (sum 56).
REQ-018 Encryption key i SHALL be the key i-1 halves each rotated left by s[i]; key 0 is the latched halves rotated left by s[0].
REQ-019 Decryption key 0 SHALL equal the latched C0/D0 unrotated.
REQ-020 Decryption key i (i>=1) SHALL be the key i-1 halves each rotated right by s[16-i], i.e. rotate-right amounts 2,4,4,4,4,4,4,2,4,4,4,4,4,4,2.
REQ-021 Both halves SHALL rotate independently as 56-bit circular quantities; no bits cross between Ck and Dk.
REQ-022 Handshake rule: a key is accepted when Key_valid and Key_ready are both high on a rising edge.
REQ-023 On acceptance, the next key and Round_idx+1 SHALL appear in the following cycle.
REQ-024 Stall: while Key_valid=1 and Key_ready=0, Ck, Dk and Round_idx SHALL hold stable.
REQ-025 Key_valid SHALL NOT drop before acceptance.
REQ-026 Round_idx SHALL NOT wrap; acceptance at index 15 SHALL deassert Key_valid in the next cycle, which is the DONE cycle.
REQ-027 Start while Busy or in DONE SHALL be ignored, with no effect on latched data or mode.
REQ-028 Changes on C0_in, D0_in or Decrypt after the latch SHALL have no effect on the schedule in progress.
REQ-029 In IDLE and DONE, Key_valid SHALL be 0; Ck and Dk SHALL hold their last value.
REQ-030 Start asserted in the same cycle as Done SHALL be ignored; a new schedule may start from the following cycle in IDLE.

Reset
REQ-031 Reset_n low SHALL asynchronously force:
- state to IDLE;
- Key_valid, Busy and Done to 0;
- Round_idx to 0;
- Ck and Dk to 56'h0;
- latched mode to 0.
REQ-032 Reset mid-schedule SHALL abandon the schedule with no Done pulse.
REQ-033 After reset release, the block SHALL accept Start from the first rising edge.

Verification
REQ-034 Encryption check: C0_in=56'h1, D0_in=56'h80000000000000, Decrypt=0, Key_ready=1, Start pulse.
- Key 0: Ck=56'h4, Dk=56'h2.
- Key 15: Ck=56'h1, Dk=56'h80000000000000.
- Done pulse one cycle after key 15.
REQ-035 Decryption check: C0_in=56'h1, Decrypt=1.
- Key 0: Ck=56'h1.
- Key 1: Ck=56'h40000000000000.
- Keys 0..15 SHALL equal the encryption keys for the same C0_in/D0_in in reverse order.
REQ-036 Stall check: hold Key_ready=0 for 5 cycles at Round_idx=3.
- Outputs SHALL be stable throughout the stall.
- Round_idx=4 SHALL appear one cycle after Key_ready returns to 1.
REQ-037 Start-while-busy check: assert Start with new C0_in at Round_idx=7.
- The schedule SHALL continue unchanged.
- Exactly 16 keys and one Done pulse SHALL be produced.
REQ-038 Reset-mid-operation check: pull Reset_n low asynchronously at Round_idx=9, between clock edges.
- Key_valid=0, Busy=0, Ck=0 and Dk=0 SHALL take effect immediately, without waiting for a clock edge.
- No Done pulse SHALL occur.
- A fresh Start after release SHALL yield correct key 0.
